seg_scan_drv: RTL and testbench



---
 rtl/seg_scan_drv.sv | 150 +++++++++++++++
 tb/tb_seg_scan_drv.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv.sv
// Multiplexed common-anode seven-segment scan driver with frame-coherent snapshot.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_drv #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam state_t ST_INIT = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [IDX_W-1:0]        idx, idx_d;
    logic [VAL_W-1:0]        snap_value, snap_value_d;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_n_d;
    logic                    frame_done_d;
    logic [3:0]              digit;
    logic                    digit_dp;
    logic                    lit;
`ifdef SEG_LZB_EN
    logic                    lz_run;
    logic                    lz_sel;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan sequencing, snapshot capture and registered output decode.
    always_comb begin
        cnt_d        = cnt;
        idx_d        = idx;
        snap_value_d = snap_value;
        snap_dp_d    = snap_dp;
        frame_done_d = 1'b0;
        digit        = 4'h0;
        digit_dp     = 1'b0;
        an_d         = '1;

        if (cnt == CNT_LAST) begin
            cnt_d = '0;
            if (idx == IDX_LAST) begin
                idx_d        = '0;
                snap_value_d = value;
                snap_dp_d    = dp;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx + 1'b1;
            end
        end else begin
            cnt_d = cnt + 1'b1;
        end

        state_d = (32'(cnt_d) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit    = snap_value[4*i +: 4];
                digit_dp = snap_dp[i];
            end
        end

        seg_d  = hex7(digit);
        dp_n_d = ~digit_dp;
        lit    = (state == ST_DRIVE) && en;

`ifdef SEG_LZB_EN
        // A digit is a leading zero when it and all higher digits are zero.
        lz_run = 1'b1;
        lz_sel = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (snap_value[4*i +: 4] != 4'h0) lz_run = 1'b0;
            if (idx == IDX_W'(i)) lz_sel = lz_run;
        end
        if (lz_sel && !digit_dp && (idx != '0)) lit = 1'b0;
`endif

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx == IDX_W'(i))) an_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            cnt        <= '0;
            idx        <= '0;
            snap_value <= '0;
            snap_dp    <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            snap_value <= snap_value_d;
            snap_dp    <= snap_dp_d;
            an         <= an_d;
            seg        <= seg_d;
            dp_n       <= dp_n_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Define SEG_LZB_EN for both bench and RTL to exercise leading-zero blanking.
module tb_seg_scan_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    seg_scan_drv #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .value     (value),
        .dp        (dp),
        .an        (an),
        .seg       (seg),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after edge k (edges counted from reset release).
    task automatic step_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dpn);
        chk({tag, ".an"}, 32'(an), 32'(e_an));
        chk({tag, ".seg"}, 32'(seg), 32'(e_seg));
        chk({tag, ".dp_n"}, 32'(dp_n), 32'(e_dpn));
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        value = 16'h1234;
        dp    = 4'b0001;

        #2;
        chk_out("rst0", 4'hF, 7'h7F, 1'b1);
        chk("rst0.fd", 32'(frame_done), 32'd0);
        #10;
        rst = 1'b0;
        cyc = 0;

        // First frame shows the cleared snapshot
        step_to(1);  chk("f1.blank1", 32'(an), 32'hF);
        step_to(2);  chk("f1.blank2", 32'(an), 32'hF);
        step_to(3);  chk_out("f1.d0", 4'hE, 7'h40, 1'b1);
        step_to(11); chk_out("f1.d1", 4'hD, 7'h40, 1'b1);
        step_to(31); chk("f1.fd31", 32'(frame_done), 32'd0);
        step_to(32); chk("f1.fd32", 32'(frame_done), 32'd1);
                     chk_out("f1.d3", 4'h7, 7'h40, 1'b1);
        step_to(33); chk("f2.fd33", 32'(frame_done), 32'd0);
                     chk("f2.blank", 32'(an), 32'hF);
        step_to(34); chk("f2.blank2", 32'(an), 32'hF);
        step_to(35); chk_out("f2.d0", 4'hE, 7'h19, 1'b0);
        step_to(40); chk_out("f2.d0end", 4'hE, 7'h19, 1'b0);
        step_to(41); chk("f2.s1blank", 32'(an), 32'hF);
        step_to(43); chk_out("f2.d1", 4'hD, 7'h30, 1'b1);

        // Mid-frame change must not tear the current frame
        step_to(50); value = 16'hFFFF;
        step_to(51); chk_out("tear.d2", 4'hB, 7'h24, 1'b1);
        step_to(59); chk_out("tear.d3", 4'h7, 7'h79, 1'b1);
        step_to(64); chk("f2.fd64", 32'(frame_done), 32'd1);
        step_to(67); chk_out("f3.d0", 4'hE, 7'h0E, 1'b0);
        step_to(83); chk_out("f3.d2", 4'hB, 7'h0E, 1'b1);
        step_to(96); chk_out("f3.d3", 4'h7, 7'h0E, 1'b1);

        // Disabled frame: anodes off, scan keeps running
        en = 1'b0;
        step_to(99);  chk("en0.d0", 32'(an), 32'hF);
        step_to(107); chk("en0.d1", 32'(an), 32'hF);
        step_to(115); chk("en0.d2", 32'(an), 32'hF);
        step_to(123); chk("en0.d3", 32'(an), 32'hF);
        step_to(127); chk("en0.fd127", 32'(frame_done), 32'd0);
        step_to(128); chk("en0.fd128", 32'(frame_done), 32'd1);
        en = 1'b1;
        step_to(131); chk_out("en1.d0", 4'hE, 7'h0E, 1'b0);
        step_to(147); chk_out("en1.d2", 4'hB, 7'h0E, 1'b1);

        // Asynchronous reset in the middle of digit 2 drive
        step_to(148);
        #2;
        rst = 1'b1;
        #1;
        chk_out("arst", 4'hF, 7'h7F, 1'b1);
        chk("arst.fd", 32'(frame_done), 32'd0);
        #1;
        rst   = 1'b0;
        cyc   = 0;
        value = 16'h0070;
        dp    = 4'b0000;
        step_to(1);  chk("arst.blank", 32'(an), 32'hF);
        step_to(3);  chk_out("arst.d0", 4'hE, 7'h40, 1'b1);
        step_to(31); chk("arst.fd31", 32'(frame_done), 32'd0);
        step_to(32); chk("arst.fd32", 32'(frame_done), 32'd1);

`ifdef SEG_LZB_EN
        step_to(35); chk_out("lzb.d0", 4'hE, 7'h40, 1'b1);
        step_to(43); chk_out("lzb.d1", 4'hD, 7'h78, 1'b1);
        step_to(51); chk("lzb.d2", 32'(an), 32'hF);
        step_to(59); chk("lzb.d3", 32'(an), 32'hF);
        value = 16'h0000;
        step_to(67); chk_out("lzb0.d0", 4'hE, 7'h40, 1'b1);
        step_to(75); chk("lzb0.d1", 32'(an), 32'hF);
        step_to(83); chk("lzb0.d2", 32'(an), 32'hF);
        step_to(91); chk("lzb0.d3", 32'(an), 32'hF);
`else
        step_to(35); chk_out("nolzb.d0", 4'hE, 7'h40, 1'b1);
        step_to(43); chk_out("nolzb.d1", 4'hD, 7'h78, 1'b1);
        step_to(51); chk_out("nolzb.d2", 4'hB, 7'h40, 1'b1);
        step_to(59); chk_out("nolzb.d3", 4'h7, 7'h40, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
